// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU issue sequencer: ALU op codes, MIPS opcode/funct
// values and the FSM state encoding.
package alu_sequencer_pkg;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_OR    = 4'd2;
   localparam logic [3:0] OP_AND   = 4'd3;
   localparam logic [3:0] OP_NOR   = 4'd4;
   localparam logic [3:0] OP_SLT   = 4'd5;
   localparam logic [3:0] OP_SLTEQ = 4'd6;
   localparam logic [3:0] OP_EQ    = 4'd7;
   localparam logic [3:0] OP_SLL   = 4'd8;
   localparam logic [3:0] OP_SRL   = 4'd9;
   localparam logic [3:0] OP_NEQ   = 4'd10;
   localparam logic [3:0] OP_GT    = 4'd11;
   localparam logic [3:0] OP_GTEQ  = 4'd12;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_SLTI  = 6'h0A;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTEQ = 6'h30;
   localparam logic [5:0] FN_EQ    = 6'h31;
   localparam logic [5:0] FN_NEQ   = 6'h32;
   localparam logic [5:0] FN_GT    = 6'h33;
   localparam logic [5:0] FN_GTEQ  = 6'h34;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_READ   = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4
   } state_t;

endpackage

// File: rtl/alu_sequencer_decode.sv
// Combinational instruction decoder: MIPS word -> ALU op, destination register,
// immediate selection/extension, shift amount and an illegal flag.
module alu_sequencer_decode
   import alu_sequencer_pkg::*;
#(
   parameter int EXT_OPS = 1
) (
   input  logic [31:0] instr,
   output logic [3:0]  alu_op,
   output logic [4:0]  dest,
   output logic        imm_sel,
   output logic        sext,
   output logic [4:0]  shamt,
   output logic        illegal
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       ext_en;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];
   assign ext_en = (EXT_OPS != 0);

   // Decode table; illegal words leave alu_op at add (0) so the ALU sees a benign op.
   always_comb begin
      alu_op  = OP_ADD;
      dest    = 5'd0;
      imm_sel = 1'b0;
      sext    = 1'b0;
      shamt   = 5'd0;
      illegal = 1'b0;
      case (opcode)
         OPC_RTYPE: begin
            dest = instr[15:11];
            case (funct)
               FN_ADD, FN_ADDU: alu_op = OP_ADD;
               FN_SUB, FN_SUBU: alu_op = OP_SUB;
               FN_AND:          alu_op = OP_AND;
               FN_OR:           alu_op = OP_OR;
               FN_NOR:          alu_op = OP_NOR;
               FN_SLT:          alu_op = OP_SLT;
               FN_SLL: begin
                  alu_op = OP_SLL;
                  shamt  = instr[10:6];
               end
               FN_SRL: begin
                  alu_op = OP_SRL;
                  shamt  = instr[10:6];
               end
               FN_SLTEQ: if (ext_en) alu_op = OP_SLTEQ; else illegal = 1'b1;
               FN_EQ:    if (ext_en) alu_op = OP_EQ;    else illegal = 1'b1;
               FN_NEQ:   if (ext_en) alu_op = OP_NEQ;   else illegal = 1'b1;
               FN_GT:    if (ext_en) alu_op = OP_GT;    else illegal = 1'b1;
               FN_GTEQ:  if (ext_en) alu_op = OP_GTEQ;  else illegal = 1'b1;
               default:  illegal = 1'b1;
            endcase
         end
         OPC_ADDI: begin
            alu_op  = OP_ADD;
            dest    = instr[20:16];
            imm_sel = 1'b1;
            sext    = 1'b1;
         end
         OPC_SLTI: begin
            alu_op  = OP_SLT;
            dest    = instr[20:16];
            imm_sel = 1'b1;
            sext    = 1'b1;
         end
         OPC_ANDI: begin
            alu_op  = OP_AND;
            dest    = instr[20:16];
            imm_sel = 1'b1;
         end
         OPC_ORI: begin
            alu_op  = OP_OR;
            dest    = instr[20:16];
            imm_sel = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) begin
         alu_op = OP_ADD;
         shamt  = 5'd0;
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle issue controller in front of the 32-bit ALU and register file:
// IDLE -> DECODE -> READ -> EXEC -> WB, one instruction at a time.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int RA_W    = 5,
   parameter int EXT_OPS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [31:0]       in_instr,
   output logic              in_ready,
   output logic [RA_W-1:0]   rf_rs_addr,
   output logic [RA_W-1:0]   rf_rt_addr,
   input  logic [DATA_W-1:0] rf_rs_data,
   input  logic [DATA_W-1:0] rf_rt_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_op,
   output logic [4:0]        alu_shamt,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_cout,
   output logic              rf_we,
   output logic [RA_W-1:0]   rf_wa,
   output logic [DATA_W-1:0] rf_wd,
   output logic              done,
   output logic              illegal,
   output logic              carry_flag
);

   state_t            state_q, state_d;
   logic [31:0]       instr_q, instr_d;
   logic              in_ready_q, in_ready_d;
   logic [RA_W-1:0]   rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d;
   logic [3:0]        dec_op_q, dec_op_d;
   logic [4:0]        dec_dest_q, dec_dest_d;
   logic [DATA_W-1:0] dec_imm_q, dec_imm_d;
   logic              dec_imm_sel_q, dec_imm_sel_d;
   logic [4:0]        dec_shamt_q, dec_shamt_d;
   logic              dec_ill_q, dec_ill_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [3:0]        alu_op_q, alu_op_d;
   logic [4:0]        alu_shamt_q, alu_shamt_d;
   logic              rf_we_q, rf_we_d;
   logic [RA_W-1:0]   rf_wa_q, rf_wa_d;
   logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
   logic              done_q, done_d;
   logic              illegal_q, illegal_d;
   logic              carry_q, carry_d;

   logic [3:0]        w_op;
   logic [4:0]        w_dest;
   logic              w_imm_sel, w_sext, w_ill;
   logic [4:0]        w_shamt;
   logic              accept;

   alu_sequencer_decode #(.EXT_OPS(EXT_OPS)) u_decode (
      .instr   (instr_q),
      .alu_op  (w_op),
      .dest    (w_dest),
      .imm_sel (w_imm_sel),
      .sext    (w_sext),
      .shamt   (w_shamt),
      .illegal (w_ill)
   );

   assign accept = in_valid && in_ready_q;

   // Next-state and datapath register inputs; strobes default low every cycle.
   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      rs_addr_d     = rs_addr_q;
      rt_addr_d     = rt_addr_q;
      dec_op_d      = dec_op_q;
      dec_dest_d    = dec_dest_q;
      dec_imm_d     = dec_imm_q;
      dec_imm_sel_d = dec_imm_sel_q;
      dec_shamt_d   = dec_shamt_q;
      dec_ill_d     = dec_ill_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_op_d      = alu_op_q;
      alu_shamt_d   = alu_shamt_q;
      rf_wa_d       = rf_wa_q;
      rf_wd_d       = rf_wd_q;
      carry_d       = carry_q;
      rf_we_d       = 1'b0;
      done_d        = 1'b0;
      illegal_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               instr_d   = in_instr;
               // Addresses go out during DECODE so read data is ready in READ.
               rs_addr_d = RA_W'(in_instr[25:21]);
               rt_addr_d = RA_W'(in_instr[20:16]);
               state_d   = ST_DECODE;
            end
         end
         ST_DECODE: begin
            dec_op_d      = w_op;
            dec_dest_d    = w_dest;
            dec_imm_d     = w_sext ? {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]}
                                   : {{(DATA_W-16){1'b0}}, instr_q[15:0]};
            dec_imm_sel_d = w_imm_sel;
            dec_shamt_d   = w_shamt;
            dec_ill_d     = w_ill;
            state_d       = ST_READ;
         end
         ST_READ: begin
            alu_a_d     = rf_rs_data;
            alu_b_d     = dec_imm_sel_q ? dec_imm_q : rf_rt_data;
            alu_op_d    = dec_op_q;
            alu_shamt_d = dec_shamt_q;
            state_d     = ST_EXEC;
         end
         ST_EXEC: begin
            rf_wd_d   = alu_out;
            rf_wa_d   = RA_W'(dec_dest_q);
            rf_we_d   = !dec_ill_q && (dec_dest_q != 5'd0);
            done_d    = 1'b1;
            illegal_d = dec_ill_q;
            if (!dec_ill_q && dec_op_q == OP_ADD) carry_d = alu_cout;
            state_d   = ST_WB;
         end
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      in_ready_d = (state_d == ST_IDLE);
   end

   // State and output registers; reset clears everything, aborting any instruction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         instr_q       <= '0;
         in_ready_q    <= 1'b0;
         rs_addr_q     <= '0;
         rt_addr_q     <= '0;
         dec_op_q      <= '0;
         dec_dest_q    <= '0;
         dec_imm_q     <= '0;
         dec_imm_sel_q <= 1'b0;
         dec_shamt_q   <= '0;
         dec_ill_q     <= 1'b0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_op_q      <= '0;
         alu_shamt_q   <= '0;
         rf_we_q       <= 1'b0;
         rf_wa_q       <= '0;
         rf_wd_q       <= '0;
         done_q        <= 1'b0;
         illegal_q     <= 1'b0;
         carry_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         in_ready_q    <= in_ready_d;
         rs_addr_q     <= rs_addr_d;
         rt_addr_q     <= rt_addr_d;
         dec_op_q      <= dec_op_d;
         dec_dest_q    <= dec_dest_d;
         dec_imm_q     <= dec_imm_d;
         dec_imm_sel_q <= dec_imm_sel_d;
         dec_shamt_q   <= dec_shamt_d;
         dec_ill_q     <= dec_ill_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_op_q      <= alu_op_d;
         alu_shamt_q   <= alu_shamt_d;
         rf_we_q       <= rf_we_d;
         rf_wa_q       <= rf_wa_d;
         rf_wd_q       <= rf_wd_d;
         done_q        <= done_d;
         illegal_q     <= illegal_d;
         carry_q       <= carry_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign rf_rs_addr = rs_addr_q;
   assign rf_rt_addr = rt_addr_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign alu_shamt  = alu_shamt_q;
   assign rf_we      = rf_we_q;
   assign rf_wa      = rf_wa_q;
   assign rf_wd      = rf_wd_q;
   assign done       = done_q;
   assign illegal    = illegal_q;
   assign carry_flag = carry_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural register file and ALU.
module tb_alu_sequencer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_instr;
   logic        in_ready;
   logic [4:0]  rf_rs_addr, rf_rt_addr;
   logic [31:0] rf_rs_data, rf_rt_data;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_op;
   logic [4:0]  alu_shamt;
   logic [31:0] alu_out;
   logic        alu_cout;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic        done;
   logic        illegal;
   logic        carry_flag;

   int total = 0;
   int bad   = 0;
   int acc_cnt = 0;
   int done_cnt = 0;
   int we_cnt = 0;
   int a0, d0, w0;

   logic [31:0] rf_mem [0:31];

   alu_sequencer #(.DATA_W(32), .RA_W(5), .EXT_OPS(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_instr   (in_instr),
      .in_ready   (in_ready),
      .rf_rs_addr (rf_rs_addr),
      .rf_rt_addr (rf_rt_addr),
      .rf_rs_data (rf_rs_data),
      .rf_rt_data (rf_rt_data),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_shamt  (alu_shamt),
      .alu_out    (alu_out),
      .alu_cout   (alu_cout),
      .rf_we      (rf_we),
      .rf_wa      (rf_wa),
      .rf_wd      (rf_wd),
      .done       (done),
      .illegal    (illegal),
      .carry_flag (carry_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: synchronous read, data one cycle after the address.
   always @(posedge clk) begin
      rf_rs_data <= rf_mem[rf_rs_addr];
      rf_rt_data <= rf_mem[rf_rt_addr];
   end

   // Behavioural ALU.
   always_comb begin
      alu_out  = 32'd0;
      alu_cout = 1'b0;
      case (alu_op)
         4'd0:  {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
         4'd1:  alu_out = alu_a - alu_b;
         4'd2:  alu_out = alu_a | alu_b;
         4'd3:  alu_out = alu_a & alu_b;
         4'd4:  alu_out = ~(alu_a | alu_b);
         4'd5:  alu_out = {31'd0, $signed(alu_a) <  $signed(alu_b)};
         4'd6:  alu_out = {31'd0, $signed(alu_a) <= $signed(alu_b)};
         4'd7:  alu_out = {31'd0, alu_a == alu_b};
         4'd8:  alu_out = alu_b << alu_shamt;
         4'd9:  alu_out = alu_b >> alu_shamt;
         4'd10: alu_out = {31'd0, alu_a != alu_b};
         4'd11: alu_out = {31'd0, $signed(alu_a) >  $signed(alu_b)};
         4'd12: alu_out = {31'd0, $signed(alu_a) >= $signed(alu_b)};
         default: alu_out = 32'd0;
      endcase
   end

   // Event counters for the back-to-back acceptance check.
   always @(posedge clk) begin
      if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
      if (done)                 done_cnt <= done_cnt + 1;
      if (rf_we)                we_cnt <= we_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for a single accept edge; returns 1ns after that edge.
   task automatic issue(input logic [31:0] instr);
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = instr;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
      rf_mem[1] = 32'd5;
      rf_mem[2] = 32'd7;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_instr = 32'd0;

      // Reset state
      repeat (3) tick();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_done",     {31'd0, done}, 32'd0);
      chk("rst_rf_we",    {31'd0, rf_we}, 32'd0);
      chk("rst_carry",    {31'd0, carry_flag}, 32'd0);
      chk("rst_alu_op",   {28'd0, alu_op}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

      // add r3 = r1 + r2 = 12
      issue(32'h0022_1820);
      chk("add_busy_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("add_read_done", {31'd0, done}, 32'd0);
      tick();
      chk("add_alu_a",  alu_a, 32'd5);
      chk("add_alu_b",  alu_b, 32'd7);
      chk("add_alu_op", {28'd0, alu_op}, 32'd0);
      chk("add_exec_done", {31'd0, done}, 32'd0);
      tick();
      chk("add_done",  {31'd0, done}, 32'd1);
      chk("add_we",    {31'd0, rf_we}, 32'd1);
      chk("add_wa",    {27'd0, rf_wa}, 32'd3);
      chk("add_wd",    rf_wd, 32'd12);
      chk("add_carry", {31'd0, carry_flag}, 32'd0);
      chk("add_ill",   {31'd0, illegal}, 32'd0);
      tick();
      chk("add_done_low", {31'd0, done}, 32'd0);
      chk("add_we_low",   {31'd0, rf_we}, 32'd0);
      chk("add_ready",    {31'd0, in_ready}, 32'd1);

      // addi r4 = r1 + sext(FFFF) = 4 with carry out
      issue(32'h2024_FFFF);
      tick();
      tick();
      chk("addi_alu_b", alu_b, 32'hFFFF_FFFF);
      tick();
      chk("addi_we",    {31'd0, rf_we}, 32'd1);
      chk("addi_wa",    {27'd0, rf_wa}, 32'd4);
      chk("addi_wd",    rf_wd, 32'd4);
      chk("addi_carry", {31'd0, carry_flag}, 32'd1);
      tick();

      // sll r5 = r2 << 4 with r2 = 1; carry must hold
      rf_mem[2] = 32'd1;
      issue(32'h0002_2900);
      tick();
      tick();
      chk("sll_alu_b",  alu_b, 32'd1);
      chk("sll_shamt",  {27'd0, alu_shamt}, 32'd4);
      chk("sll_alu_op", {28'd0, alu_op}, 32'd8);
      tick();
      chk("sll_wa",    {27'd0, rf_wa}, 32'd5);
      chk("sll_wd",    rf_wd, 32'd16);
      chk("sll_carry", {31'd0, carry_flag}, 32'd1);
      tick();

      // eq r6 = (r1 == r1): custom compare, legal with extensions enabled
      issue(32'h0021_3031);
      tick();
      tick();
      chk("eq_alu_op",  {28'd0, alu_op}, 32'd7);
      chk("eq_shamt",   {27'd0, alu_shamt}, 32'd0);
      tick();
      chk("eq_wd",  rf_wd, 32'd1);
      chk("eq_ill", {31'd0, illegal}, 32'd0);
      chk("eq_we",  {31'd0, rf_we}, 32'd1);
      tick();

      // opcode 3Fh: illegal
      issue(32'hFC22_1820);
      tick();
      tick();
      chk("ill_alu_op", {28'd0, alu_op}, 32'd0);
      tick();
      chk("ill_illegal", {31'd0, illegal}, 32'd1);
      chk("ill_done",    {31'd0, done}, 32'd1);
      chk("ill_we",      {31'd0, rf_we}, 32'd0);
      chk("ill_carry",   {31'd0, carry_flag}, 32'd1);
      tick();
      chk("ill_ready",     {31'd0, in_ready}, 32'd1);
      chk("ill_pulse_low", {31'd0, illegal}, 32'd0);

      // Reset while an addi is in EXEC: aborted, carry cleared
      issue(32'h2024_FFFF);
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b0;
      tick();
      chk("abort_done",  {31'd0, done}, 32'd0);
      chk("abort_we",    {31'd0, rf_we}, 32'd0);
      chk("abort_ready", {31'd0, in_ready}, 32'd0);
      chk("abort_carry", {31'd0, carry_flag}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("abort_rel_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_rel_done",  {31'd0, done}, 32'd0);

      // add r0 = r1 + r2 with in_valid held through busy
      a0 = acc_cnt;
      d0 = done_cnt;
      w0 = we_cnt;
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = 32'h0022_0020;
      repeat (10) tick();
      in_valid = 1'b0;
      repeat (3) tick();
      chk("hold_accepts", acc_cnt - a0, 32'd2);
      chk("hold_dones",   done_cnt - d0, 32'd2);
      chk("hold_we",      we_cnt - w0, 32'd0);
      chk("hold_ready",   {31'd0, in_ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
